// File: rtl/midi_tx.sv
// Serial MIDI transmitter: one channel/system message per handshake, sent as
// 8N1 UART frames at BAUD with optional running-status compression.
module midi_tx #(
    parameter int CLK_FREQ       = 50_000_000,
    parameter int BAUD           = 31_250,
    parameter int RUNNING_STATUS = 1
) (
    input  logic       clk_i,
    input  logic       nrst_i,
    input  logic       msgValid_i,
    output logic       msgReady_o,
    input  logic [7:0] status_i,
    input  logic [6:0] data1_i,
    input  logic [6:0] data2_i,
    output logic       txData_o,
    output logic       busy_o
);

    localparam int DIV   = CLK_FREQ / BAUD;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'(DIV - 2);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        START = 3'd2,
        DATA  = 3'd3,
        STOP  = 3'd4
    } state_t;

    state_t           state, state_next;
    logic [DIV_W-1:0] div_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift_q;
    logic [7:0]       byte_q0, byte_q1, byte_q2;
    logic [1:0]       frames_left;
    logic [7:0]       last_status;
    logic             msg_pending;
    logic             sent_any;
    logic             accept;

    logic             is_status, is_channel, is_realtime, one_data, skip_status;
    logic [1:0]       load_count;
    logic [7:0]       load_b0, load_b1, load_b2;

    assign accept = msgValid_i & msgReady_o;

    // Build the frame queue straight from the inputs so the accept edge latches it.
    always_comb begin
        is_status   = status_i[7];
        is_channel  = status_i[7] && (status_i[6:4] != 3'b111);
        is_realtime = (status_i[7:3] == 5'b11111);
        one_data    = (status_i[6:5] == 2'b10);
        skip_status = (RUNNING_STATUS != 0) && is_channel && (status_i == last_status);
        load_b0     = status_i;
        load_b1     = {1'b0, data1_i};
        load_b2     = {1'b0, data2_i};
        load_count  = 2'd0;
        if (!is_status) begin
            load_count = 2'd0;
        end else if (!is_channel) begin
            load_count = 2'd1;
        end else if (skip_status) begin
            load_b0    = {1'b0, data1_i};
            load_b1    = {1'b0, data2_i};
            load_count = one_data ? 2'd1 : 2'd2;
        end else begin
            load_count = one_data ? 2'd2 : 2'd3;
        end
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Between bytes the final stop-bit cycle doubles as LOAD, keeping frames back-to-back.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (msg_pending && (frames_left != 2'd0)) begin
                    state_next = LOAD;
                end
            end
            LOAD:  state_next = START;
            START: begin
                if (div_cnt == DIV_LAST) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if ((div_cnt == DIV_LAST) && (bit_cnt == 3'd7)) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if ((frames_left != 2'd0) && (div_cnt == DIV_PRE)) begin
                    state_next = LOAD;
                end else if ((frames_left == 2'd0) && (div_cnt == DIV_LAST)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        txData_o   = 1'b1;
        busy_o     = 1'b0;
        msgReady_o = 1'b0;
        case (state)
            IDLE:  msgReady_o = !msg_pending;
            LOAD:  busy_o = sent_any;
            START: begin
                txData_o = 1'b0;
                busy_o   = 1'b1;
            end
            DATA: begin
                txData_o = shift_q[0];
                busy_o   = 1'b1;
            end
            STOP:  busy_o = 1'b1;
            default: ;
        endcase
    end

    // Message capture, byte queue and running-status tracking.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            byte_q0     <= 8'h00;
            byte_q1     <= 8'h00;
            byte_q2     <= 8'h00;
            shift_q     <= 8'h00;
            frames_left <= 2'd0;
            last_status <= 8'h00;
            msg_pending <= 1'b0;
        end else begin
            if (accept) begin
                byte_q0     <= load_b0;
                byte_q1     <= load_b1;
                byte_q2     <= load_b2;
                frames_left <= load_count;
                msg_pending <= 1'b1;
                if (is_channel) begin
                    last_status <= status_i;
                end else if (is_status && !is_realtime) begin
                    last_status <= 8'h00;
                end
            end else if ((state == IDLE) && msg_pending) begin
                msg_pending <= 1'b0;
            end

            if (state == LOAD) begin
                shift_q     <= byte_q0;
                byte_q0     <= byte_q1;
                byte_q1     <= byte_q2;
                frames_left <= frames_left - 2'd1;
            end else if ((state == DATA) && (div_cnt == DIV_LAST)) begin
                shift_q <= {1'b0, shift_q[7:1]};
            end
        end
    end

    // Bit-time divider, data bit index and the "a frame has started" flag.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            div_cnt  <= '0;
            bit_cnt  <= 3'd0;
            sent_any <= 1'b0;
        end else begin
            if (((state == START) || (state == DATA) || (state == STOP)) &&
                (state_next == state) && (div_cnt != DIV_LAST)) begin
                div_cnt <= div_cnt + DIV_W'(1);
            end else begin
                div_cnt <= '0;
            end

            if (state == LOAD) begin
                bit_cnt <= 3'd0;
            end else if ((state == DATA) && (div_cnt == DIV_LAST)) begin
                bit_cnt <= bit_cnt + 3'd1;
            end

            if (state == START) begin
                sent_any <= 1'b1;
            end else if (state == IDLE) begin
                sent_any <= 1'b0;
            end
        end
    end

endmodule
